hex_keypad_scanner: RTL

- Scanning controller for the 4x4 hex keypad: drives one-hot column strobes, samples the row lines, and debounces contacts.
- Emits a 4-bit key code with a single-cycle valid pulse per press.
- Sits between the physical keypad (or the bench keypad model that turns key[15:0] into rows) and downstream consumers of code/valid.

---
 rtl/hex_keypad_pkg.sv | 39 +++
 rtl/keypad_row_sync.sv | 25 ++
 rtl/hex_keypad_scanner.sv | 114 +++++++++++
 3 files changed

// File: rtl/hex_keypad_pkg.sv
// Shared types, constants and small helpers for the hex keypad scanner.
package hex_keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_SCAN_DIV = 4;
  localparam int unsigned DEFAULT_DEBOUNCE = 8;
  localparam logic [3:0]  COL_RESET        = 4'b0001;

  // Index of the lowest asserted row; lower rows win when several share a column.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Binary index of a one-hot column strobe.
  function automatic logic [1:0] col_index(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Next column in scan order: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  function automatic logic [3:0] rotate_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer bringing the asynchronous row sense lines into clk.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] row_s
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Two-stage capture of the row lines, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 4'h0;
      r_sync <= 4'h0;
    end else begin
      r_meta <= row;
      r_sync <= r_meta;
    end
  end

  assign row_s = r_sync;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column strobing, row sampling, press/release debounce.
module hex_keypad_scanner
  import hex_keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DEFAULT_SCAN_DIV,
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       valid
);

  localparam int unsigned DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DB_TARGET = 8'(DEBOUNCE);

  logic [3:0] w_row_s;
  logic       w_sample;
  logic [7:0] w_cnt_inc;

  state_e           r_state;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_cnt;
  logic [3:0]       r_col;
  logic [3:0]       r_code;
  logic             r_valid;
  logic [3:0]       r_cand;
  logic [3:0]       r_pattern;

  keypad_row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row   (row),
    .row_s (w_row_s)
  );

  // Rows are only trusted on the last cycle of a column window, after the synchronizer settles.
  assign w_sample  = (r_div == DIV_LAST);
  assign w_cnt_inc = (r_cnt == DB_TARGET) ? r_cnt : r_cnt + 8'd1;

  // Scan / debounce / held controller with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SCAN;
      r_div     <= '0;
      r_cnt     <= 8'd0;
      r_col     <= COL_RESET;
      r_code    <= 4'h0;
      r_valid   <= 1'b0;
      r_cand    <= 4'h0;
      r_pattern <= 4'h0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_sample) begin
            r_div <= '0;
            if (w_row_s == 4'h0) begin
              r_col <= rotate_col(r_col);
            end else begin
              r_cand    <= {lowest_row(w_row_s), col_index(r_col)};
              r_pattern <= w_row_s;
              r_cnt     <= 8'd0;
              r_state   <= ST_DEBOUNCE;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (w_row_s == r_pattern) begin
            if (w_cnt_inc == DB_TARGET) begin
              r_code  <= r_cand;
              r_valid <= 1'b1;
              r_cnt   <= 8'd0;
              r_state <= ST_HELD;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            // Bounce or release before acceptance: drop the candidate and move on.
            r_col   <= rotate_col(r_col);
            r_div   <= '0;
            r_state <= ST_SCAN;
          end
        end
        ST_HELD: begin
          // Column stays frozen; any activity on it restarts the release count.
          if (w_row_s == 4'h0) begin
            if (w_cnt_inc == DB_TARGET) begin
              r_col   <= COL_RESET;
              r_div   <= '0;
              r_cnt   <= 8'd0;
              r_state <= ST_SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else begin
            r_cnt <= 8'd0;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  assign col   = r_col;
  assign code  = r_code;
  assign valid = r_valid;

endmodule
